// File: rtl/i2s_pkg.sv
// Shared I2S constants and types: sample width, default slot length,
// word-clock channel encoding and the stereo sample struct.
package i2s_pkg;

   localparam int DATA_W        = 16;
   localparam int SLOT_BITS_DEF = 32;

   localparam logic WCLK_LEFT  = 1'b0;
   localparam logic WCLK_RIGHT = 1'b1;

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } stereo_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// MCLK divider for the I2S master: produces BCLK, the BCLK falling-edge strobe,
// the frame bit counter and the registered word clock.
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int MCLK_PER_BCLK = 4,
   parameter int SLOT_BITS     = SLOT_BITS_DEF,
   parameter int CNT_W         = $clog2(2*SLOT_BITS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             bclk_o,
   output logic             fall_stb_o,
   output logic             frame_start_o,
   output logic [CNT_W-1:0] bit_cnt_next_o,
   output logic             wclk_o
);

   localparam int HALF  = MCLK_PER_BCLK / 2;
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*SLOT_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   logic             wclk_q, wclk_d;
   logic             div_tc;
   logic             fall_stb;

   always_comb begin
      div_tc    = (div_q == DIV_LAST);
      fall_stb  = div_tc && bclk_q;
      div_d     = div_tc ? '0 : div_q + 1'b1;
      bclk_d    = div_tc ? ~bclk_q : bclk_q;
      bit_cnt_d = bit_cnt_q;
      wclk_d    = wclk_q;
      // Word clock moves with the bit counter so it is stable at BCLK rising edges.
      if (fall_stb) begin
         bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
         wclk_d    = (bit_cnt_d >= CNT_SLOT) ? WCLK_RIGHT : WCLK_LEFT;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q     <= '0;
         bclk_q    <= 1'b0;
         wclk_q    <= WCLK_RIGHT;
         bit_cnt_q <= CNT_LAST;
      end else begin
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         wclk_q    <= wclk_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bclk_o         = bclk_q;
   assign wclk_o         = wclk_q;
   assign fall_stb_o     = fall_stb;
   assign frame_start_o  = fall_stb && (bit_cnt_q == CNT_LAST);
   assign bit_cnt_next_o = bit_cnt_d;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: one-entry valid/ready holding register feeding stereo
// frame registers, serialized MSB first with one-bit delay. Option macro:
// I2S_MASTER_TX_MUTE_ON_UNDERRUN_EN (mute on underrun instead of repeating).
module i2s_master_tx
   import i2s_pkg::*;
#(
   parameter int MCLK_PER_BCLK = 4,
   parameter int SLOT_BITS     = SLOT_BITS_DEF
) (
   input  logic              AUDIO_MCLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_LDATA,
   input  logic [DATA_W-1:0] IN_RDATA,
   output logic              AUDIO_BCLK,
   output logic              AUDIO_WCLK,
   output logic              SDATA_OUT,
   output logic              SAMPLE_TR,
   output logic              UNDERRUN
);

   localparam int CNT_W = $clog2(2*SLOT_BITS);
   localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

   stereo_t           hold_q, hold_d;
   stereo_t           frame_q, frame_d;
   logic              full_q, full_d;
   logic              sdata_q, sdata_d;
   logic              sample_tr_q, sample_tr_d;
   logic              underrun_q, underrun_d;
   logic              accept;
   logic              fall_stb;
   logic              frame_start;
   logic [CNT_W-1:0]  bit_cnt_next;
   logic [CNT_W-1:0]  k;
   logic [CNT_W-1:0]  sel;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] shifted;

   i2s_clk_gen #(
      .MCLK_PER_BCLK (MCLK_PER_BCLK),
      .SLOT_BITS     (SLOT_BITS),
      .CNT_W         (CNT_W)
   ) u_clk_gen (
      .clk_i          (AUDIO_MCLK),
      .rst_i          (RESET),
      .bclk_o         (AUDIO_BCLK),
      .fall_stb_o     (fall_stb),
      .frame_start_o  (frame_start),
      .bit_cnt_next_o (bit_cnt_next),
      .wclk_o         (AUDIO_WCLK)
   );

   // Frame load uses the pre-edge holding state; an accept in the frame-start
   // cycle therefore lands in holding and goes out one frame later.
   always_comb begin
      accept      = IN_VALID && !full_q;
      hold_d      = hold_q;
      full_d      = full_q;
      frame_d     = frame_q;
      sample_tr_d = frame_start;
      underrun_d  = frame_start && !full_q;
      if (frame_start) begin
         if (full_q) begin
            frame_d = hold_q;
            full_d  = 1'b0;
         end else begin
`ifdef I2S_MASTER_TX_MUTE_ON_UNDERRUN_EN
            frame_d = '0;
`else
            frame_d = frame_q;
`endif
         end
      end
      if (accept) begin
         hold_d.left  = IN_LDATA;
         hold_d.right = IN_RDATA;
         full_d       = 1'b1;
      end

      // Slot position k of the upcoming bit; k=1 carries the MSB.
      if (bit_cnt_next >= CNT_SLOT) begin
         k    = bit_cnt_next - CNT_SLOT;
         word = frame_q.right;
      end else begin
         k    = bit_cnt_next;
         word = frame_q.left;
      end
      sel     = k - 1'b1;
      shifted = word << sel;
      sdata_d = sdata_q;
      if (fall_stb) begin
         sdata_d = ((k != '0) && (k <= CNT_DATA)) ? shifted[DATA_W-1] : 1'b0;
      end
   end

   always_ff @(posedge AUDIO_MCLK or posedge RESET) begin
      if (RESET) begin
         hold_q      <= '0;
         frame_q     <= '0;
         full_q      <= 1'b0;
         sdata_q     <= 1'b0;
         sample_tr_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         frame_q     <= frame_d;
         full_q      <= full_d;
         sdata_q     <= sdata_d;
         sample_tr_q <= sample_tr_d;
         underrun_q  <= underrun_d;
      end
   end

   assign IN_READY  = !full_q;
   assign SDATA_OUT = sdata_q;
   assign SAMPLE_TR = sample_tr_q;
   assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx: reset defaults, frame timing, serialization,
// handshake back-pressure, underrun, simultaneous accept and mid-frame reset.
module tb_i2s_master_tx;

   logic        AUDIO_MCLK = 1'b0;
   logic        RESET      = 1'b1;
   logic        IN_VALID   = 1'b0;
   logic [15:0] IN_LDATA   = '0;
   logic [15:0] IN_RDATA   = '0;
   logic        IN_READY;
   logic        AUDIO_BCLK;
   logic        AUDIO_WCLK;
   logic        SDATA_OUT;
   logic        SAMPLE_TR;
   logic        UNDERRUN;

   int passed = 0;
   int total  = 0;

`ifdef I2S_MASTER_TX_MUTE_ON_UNDERRUN_EN
   localparam logic [15:0] UR_L = 16'h0000;
   localparam logic [15:0] UR_R = 16'h0000;
`else
   localparam logic [15:0] UR_L = 16'h7FFF;
   localparam logic [15:0] UR_R = 16'h8000;
`endif

   i2s_master_tx dut (
      .AUDIO_MCLK (AUDIO_MCLK),
      .RESET      (RESET),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN_LDATA   (IN_LDATA),
      .IN_RDATA   (IN_RDATA),
      .AUDIO_BCLK (AUDIO_BCLK),
      .AUDIO_WCLK (AUDIO_WCLK),
      .SDATA_OUT  (SDATA_OUT),
      .SAMPLE_TR  (SAMPLE_TR),
      .UNDERRUN   (UNDERRUN)
   );

   // clock / watchdog
   always #5 AUDIO_MCLK = ~AUDIO_MCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      IN_LDATA = l;
      IN_RDATA = r;
      IN_VALID = 1'b1;
      @(negedge AUDIO_MCLK);
      IN_VALID = 1'b0;
   endtask

   task automatic wait_frame_start(input int budget, output int n);
      n = 0;
      do begin
         @(negedge AUDIO_MCLK);
         n++;
      end while (SAMPLE_TR !== 1'b1 && n < budget);
      check("frame_start_seen", SAMPLE_TR, 1'b1);
      check("bclk_low_at_start", AUDIO_BCLK, 1'b0);
   endtask

   // Called at the frame-start negedge; samples each BCLK-fall bit of the frame.
   task automatic capture(output logic [15:0] l, output logic [15:0] r,
                          output logic pad_ok, output logic wclk_ok, output logic rdy1);
      logic b [64];
      logic w [64];
      b[0] = SDATA_OUT;
      w[0] = AUDIO_WCLK;
      @(negedge AUDIO_MCLK);
      rdy1     = IN_READY;
      IN_VALID = 1'b0;
      repeat (3) @(negedge AUDIO_MCLK);
      b[1] = SDATA_OUT;
      w[1] = AUDIO_WCLK;
      for (int i = 2; i < 64; i++) begin
         repeat (4) @(negedge AUDIO_MCLK);
         b[i] = SDATA_OUT;
         w[i] = AUDIO_WCLK;
      end
      pad_ok  = 1'b1;
      wclk_ok = 1'b1;
      l = '0;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (w[i] !== (i >= 32)) wclk_ok = 1'b0;
         if ((i % 32 == 0) || (i % 32 > 16)) begin
            if (b[i] !== 1'b0) pad_ok = 1'b0;
         end else if (i < 32) begin
            l[16-i] = b[i];
         end else begin
            r[48-i] = b[i];
         end
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                              output logic rdy1);
      logic [15:0] l, r;
      logic pad_ok, wclk_ok;
      capture(l, r, pad_ok, wclk_ok, rdy1);
      check({tag, "_left"}, l, el);
      check({tag, "_right"}, r, er);
      check({tag, "_pad_zero"}, pad_ok, 1'b1);
      check({tag, "_wclk"}, wclk_ok, 1'b1);
   endtask

   initial begin
      int   n;
      logic rdy1;

      // reset defaults
      repeat (3) @(negedge AUDIO_MCLK);
      check("rst_bclk", AUDIO_BCLK, 1'b0);
      check("rst_wclk", AUDIO_WCLK, 1'b1);
      check("rst_sdata", SDATA_OUT, 1'b0);
      check("rst_sample_tr", SAMPLE_TR, 1'b0);
      check("rst_underrun", UNDERRUN, 1'b0);
      check("rst_ready", IN_READY, 1'b1);
      RESET = 1'b0;

      // first BCLK fall / frame start at cycle 4
      repeat (3) @(negedge AUDIO_MCLK);
      check("c3_sample_tr", SAMPLE_TR, 1'b0);
      check("c3_wclk", AUDIO_WCLK, 1'b1);
      check("c3_bclk_high", AUDIO_BCLK, 1'b1);
      @(negedge AUDIO_MCLK);
      check("f0_sample_tr", SAMPLE_TR, 1'b1);
      check("f0_underrun", UNDERRUN, 1'b1);
      check("f0_wclk_left", AUDIO_WCLK, 1'b0);
      check("f0_bclk_low", AUDIO_BCLK, 1'b0);
      @(negedge AUDIO_MCLK);
      check("f0_sample_tr_pulse", SAMPLE_TR, 1'b0);
      check("f0_underrun_pulse", UNDERRUN, 1'b0);

      // push A, then offer B while full
      IN_LDATA = 16'hA5C3;
      IN_RDATA = 16'h8001;
      IN_VALID = 1'b1;
      @(negedge AUDIO_MCLK);
      IN_LDATA = 16'h1234;
      IN_RDATA = 16'h5678;
      check("ready_full", IN_READY, 1'b0);
      repeat (5) @(negedge AUDIO_MCLK);
      check("held_off", IN_READY, 1'b0);

      wait_frame_start(300, n);
      check("f1_latency", n, 249);
      check("f1_no_underrun", UNDERRUN, 1'b0);
      check("f1_ready_back", IN_READY, 1'b1);
      check_frame("f1", 16'hA5C3, 16'h8001, rdy1);
      check("b_accepted_after_start", rdy1, 1'b0);

      wait_frame_start(300, n);
      check("f2_period", n, 4);
      check("f2_no_underrun", UNDERRUN, 1'b0);
      check_frame("f2", 16'h1234, 16'h5678, rdy1);
      check("f2_ready", rdy1, 1'b1);

      // 7FFF then two starved frames
      push(16'h7FFF, 16'h8000);
      wait_frame_start(300, n);
      check("f3_period", n, 3);
      check("f3_no_underrun", UNDERRUN, 1'b0);
      check_frame("f3", 16'h7FFF, 16'h8000, rdy1);

      wait_frame_start(300, n);
      check("f4_underrun", UNDERRUN, 1'b1);
      check_frame("f4", UR_L, UR_R, rdy1);

      wait_frame_start(300, n);
      check("f5_underrun", UNDERRUN, 1'b1);
      check_frame("f5", UR_L, UR_R, rdy1);

      // IN_VALID rises in the frame-start cycle with holding empty
      repeat (3) @(negedge AUDIO_MCLK);
      IN_LDATA = 16'h1357;
      IN_RDATA = 16'h2468;
      IN_VALID = 1'b1;
      @(negedge AUDIO_MCLK);
      IN_VALID = 1'b0;
      check("sim_sample_tr", SAMPLE_TR, 1'b1);
      check("sim_underrun", UNDERRUN, 1'b1);
      check("sim_accepted", IN_READY, 1'b0);
      check_frame("f6", UR_L, UR_R, rdy1);

      wait_frame_start(300, n);
      check("f7_period", n, 4);
      check("f7_no_underrun", UNDERRUN, 1'b0);
      check_frame("f7", 16'h1357, 16'h2468, rdy1);

      // mid-right-slot reset
      wait_frame_start(300, n);
      check("f8_underrun", UNDERRUN, 1'b1);
      push(16'hDEAD, 16'hBEEF);
      check("f8_full", IN_READY, 1'b0);
      repeat (190) @(negedge AUDIO_MCLK);
      check("mid_right_wclk", AUDIO_WCLK, 1'b1);
      RESET = 1'b1;
      #1;
      check("mrst_bclk", AUDIO_BCLK, 1'b0);
      check("mrst_wclk", AUDIO_WCLK, 1'b1);
      check("mrst_sdata", SDATA_OUT, 1'b0);
      check("mrst_sample_tr", SAMPLE_TR, 1'b0);
      check("mrst_underrun", UNDERRUN, 1'b0);
      check("mrst_ready", IN_READY, 1'b1);
      repeat (3) @(negedge AUDIO_MCLK);
      RESET = 1'b0;
      repeat (3) @(negedge AUDIO_MCLK);
      check("post_c3_sample_tr", SAMPLE_TR, 1'b0);
      @(negedge AUDIO_MCLK);
      check("post_sample_tr", SAMPLE_TR, 1'b1);
      check("post_underrun", UNDERRUN, 1'b1);
      check("post_wclk_left", AUDIO_WCLK, 1'b0);
      check_frame("post", 16'h0000, 16'h0000, rdy1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S master transmitter. Generates AUDIO_BCLK and AUDIO_WCLK from AUDIO_MCLK and serializes stereo 16-bit parallel samples onto SDATA_OUT.
- Complement to the existing I2S slave receiver/deserializer. Drives the codec DAC path when the FPGA owns the audio clocks, e.g. playing back modulated or test audio.
- Input is a valid/ready handshake into a one-entry holding register. A stereo frame is loaded at each frame start.

Parameters:
- MCLK_PER_BCLK, 4, AUDIO_MCLK cycles per BCLK period; even, at least 2.
- SLOT_BITS, 32, BCLK periods per channel slot; at least DATA_W+1.
- DATA_W, 16, sample width per channel; taken from the package.

Ports:
- AUDIO_MCLK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  stereo sample offered.
- IN_READY  out  1  holding register empty.
- IN_LDATA  in  16  left sample, two's complement.
- IN_RDATA  in  16  right sample, two's complement.
- AUDIO_BCLK  out  1  bit clock, registered.
- AUDIO_WCLK  out  1  word clock: 0 = left, 1 = right; registered.
- SDATA_OUT  out  1  serial data, registered.
- SAMPLE_TR  out  1  one-cycle pulse at frame start.
- UNDERRUN  out  1  one-cycle pulse: frame started with holding empty.

Behaviour:
- Reset values:
  - AUDIO_BCLK=0, AUDIO_WCLK=1, SDATA_OUT=0, SAMPLE_TR=0, UNDERRUN=0, IN_READY=1.
  - Holding register empty; shift/frame registers zero.
  - div_cnt=0; bit_cnt=2*SLOT_BITS-1.
- Divider:
  - div_cnt counts 0..MCLK_PER_BCLK/2-1. At its terminal value AUDIO_BCLK toggles and div_cnt returns to 0.
  - fall_stb is asserted in the cycle AUDIO_BCLK goes 1->0.
  - The first falling edge occurs MCLK_PER_BCLK cycles after reset release.
- On fall_stb:
  - bit_cnt <= (bit_cnt+1) mod 2*SLOT_BITS.
  - AUDIO_WCLK and SDATA_OUT update in the same cycle, so they are stable on BCLK rising edges.
- Slot mapping, with k = bit_cnt mod SLOT_BITS:
  - AUDIO_WCLK = (new bit_cnt >= SLOT_BITS).
  - SDATA_OUT = word[DATA_W-k] for k in 1..DATA_W, else 0. This is I2S one-bit delay, MSB first, zero-padded.
  - word is the left frame register in slot 0 and the right frame register in slot 1.
- Frame start (fall_stb with bit_cnt wrapping to 0):
  - SAMPLE_TR pulses in that cycle.
  - If holding is full: frame registers <= holding, holding marked empty.
  - If holding is empty: UNDERRUN pulses; underrun data rule is given under Optional Feature.
- Handshake:
  - IN_READY = !full, registered-state based.
  - Accept when IN_VALID && IN_READY; holding <= {IN_LDATA, IN_RDATA} and full set.
  - At most one accept per frame is effective. IN_VALID with IN_READY=0 is ignored; the producer must hold.
- Simultaneous events:
  - An accept in the same cycle as a frame start with holding empty still counts as underrun. Load uses the pre-edge holding state.
  - The new sample goes out in the next frame.
- Mid-operation reset: all state returns to reset values immediately. A partial frame is abandoned, and the next frame starts cleanly with bit_cnt wrap.
- Latency: a sample accepted before frame start N has its left MSB on SDATA_OUT at the 2nd BCLK falling edge of frame N.

Optional Feature:
- Macro: I2S_MASTER_TX_MUTE_ON_UNDERRUN_EN
- Defined: on underrun, frame registers load 0 (silence).
- Undefined: on underrun, frame registers keep the previous frame (last sample repeats).
- UNDERRUN pulses in both builds.

Decomposition:
- Package i2s_pkg:
  - DATA_W=16.
  - Default SLOT_BITS=32.
  - Left/right slot encoding constants (WCLK_LEFT=0, WCLK_RIGHT=1).
  - Stereo sample struct {left, right}.
- Sub-module i2s_clk_gen: MCLK divider producing AUDIO_BCLK, fall_stb, bit_cnt and AUDIO_WCLK.
- The top holds the handshake, holding/frame registers and bit select.

Test Plan:
- Reset release, defaults:
  - First BCLK fall at MCLK cycle 4 after release.
  - AUDIO_WCLK 1->0, SAMPLE_TR=1 for 1 cycle, UNDERRUN=1 (holding empty).
  - BCLK period 4 cycles; frame 256 cycles.
- Push L=16'hA5C3, R=16'h8001 before frame start:
  - Left slot: bits 1..16 = A5C3 MSB first; bit 0 and bits 17..31 are 0.
  - Right slot: 8001.
  - IN_READY returns to 1 at frame start.
- Present a second sample while full:
  - IN_READY=0, sample held off.
  - Accepted the cycle after frame start; appears in the following frame.
- No push for 2 frames after L=16'h7FFF:
  - UNDERRUN pulses at each frame start.
  - SDATA carries 7FFF (macro undefined) or all zeros (macro defined).
- IN_VALID rising exactly in the frame-start cycle with holding empty:
  - UNDERRUN=1.
  - Sample transmitted in the next frame, not the current one.
- Assert RESET mid-right-slot for 3 cycles:
  - Outputs return to reset values asynchronously.
  - Holding cleared, IN_READY=1.
  - Next frame start occurs 4 cycles after release.
